// File: rtl/matmul_engine_if.sv
// matmul_engine_if: groups the start/result handshake and both BRAM read ports
// of matmul_engine. The engine connects through the master modport; whoever
// owns the BRAMs and consumes results uses the slave modport.
interface matmul_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_OUT    = 16,
  parameter int ACC_WIDTH  = 32
);
  localparam int IDX_WIDTH = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                  start_matmul;
  logic                  token_rd_en;
  logic [ADDR_WIDTH-1:0] token_rd_addr;
  logic [DATA_WIDTH-1:0] token_rd_data;
  logic                  weight_rd_en;
  logic [ADDR_WIDTH-1:0] weight_rd_addr;
  logic [DATA_WIDTH-1:0] weight_rd_data;
  logic                  busy;
  logic                  result_valid;
  logic [IDX_WIDTH-1:0]  result_idx;
  logic [ACC_WIDTH-1:0]  result_data;
  logic                  done;

  modport master (
    input  start_matmul, token_rd_data, weight_rd_data,
    output token_rd_en, token_rd_addr, weight_rd_en, weight_rd_addr,
    output busy, result_valid, result_idx, result_data, done
  );

  modport slave (
    output start_matmul, token_rd_data, weight_rd_data,
    input  token_rd_en, token_rd_addr, weight_rd_en, weight_rd_addr,
    input  busy, result_valid, result_idx, result_data, done
  );
endinterface

// File: rtl/matmul_engine.sv
// matmul_engine: int8 matrix-vector multiply behind the serial loader BRAMs.
// Each 16-bit word carries two signed int8 lanes, so one word pair gives two
// MACs per cycle. Each row is FETCH (W cycles) -> DRAIN -> EMIT, and the rows
// follow back to back. A single DONE cycle follows the last row.
// Optional feature macro: MATMUL_SATURATE_EN clamps the emitted result to the
// int16 range. The accumulator itself always wraps.
module matmul_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 64,
  parameter int NUM_OUT    = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_engine_if.master   bus
);

  localparam int W         = VEC_LEN / 2;
  localparam int LANE      = DATA_WIDTH / 2;
  localparam int KW        = (W > 1) ? $clog2(W) : 1;
  localparam int IDX_WIDTH = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [KW-1:0]         K_LAST   = KW'(W - 1);
  localparam logic [KW-1:0]         K_ZERO   = {KW{1'b0}};
  localparam logic [KW-1:0]         K_ONE    = KW'(1'b1);
  localparam logic [IDX_WIDTH-1:0]  R_LAST   = IDX_WIDTH'(NUM_OUT - 1);
  localparam logic [IDX_WIDTH-1:0]  R_ZERO   = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0]  R_ONE    = IDX_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] A_ZERO   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1'b1);
  localparam logic [ACC_WIDTH-1:0]  ACC_ZERO = {ACC_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [IDX_WIDTH-1:0]   r_q, r_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  tok_addr_q, tok_addr_d;
  logic [ADDR_WIDTH-1:0]  wt_addr_q, wt_addr_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [ACC_WIDTH-1:0]   res_q, res_d;

  logic                   data_vld_q;
  logic                   first_q;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;

  logic signed [15:0]     t_lo_s, t_hi_s, w_lo_s, w_hi_s;
  logic signed [15:0]     p_lo_s, p_hi_s;
  logic [16:0]            pair_sum_s;
  logic [ACC_WIDTH-1:0]   pair_ext_s;

  // Value presented on result_data for a finished accumulator.
  function automatic logic [ACC_WIDTH-1:0] emit_value(input logic [ACC_WIDTH-1:0] acc);
`ifdef MATMUL_SATURATE_EN
    logic signed [ACC_WIDTH-1:0] sat_max;
    logic signed [ACC_WIDTH-1:0] sat_min;
    logic [ACC_WIDTH-1:0]        clamped;
    sat_max = {{(ACC_WIDTH-15){1'b0}}, 15'h7FFF};
    sat_min = {{(ACC_WIDTH-15){1'b1}}, 15'h0000};
    if ($signed(acc) > sat_max) begin
      clamped = sat_max;
    end else if ($signed(acc) < sat_min) begin
      clamped = sat_min;
    end else begin
      clamped = acc;
    end
    return clamped;
`else
    return acc;
`endif
  endfunction

  // Lane products of the word pair returned this cycle, summed and sign-extended.
  always_comb begin
    t_lo_s     = {{8{bus.token_rd_data[LANE-1]}},      bus.token_rd_data[LANE-1:0]};
    t_hi_s     = {{8{bus.token_rd_data[DATA_WIDTH-1]}}, bus.token_rd_data[DATA_WIDTH-1:LANE]};
    w_lo_s     = {{8{bus.weight_rd_data[LANE-1]}},      bus.weight_rd_data[LANE-1:0]};
    w_hi_s     = {{8{bus.weight_rd_data[DATA_WIDTH-1]}}, bus.weight_rd_data[DATA_WIDTH-1:LANE]};
    p_lo_s     = t_lo_s * w_lo_s;
    p_hi_s     = t_hi_s * w_hi_s;
    pair_sum_s = {p_lo_s[15], p_lo_s} + {p_hi_s[15], p_hi_s};
    pair_ext_s = {{(ACC_WIDTH-17){pair_sum_s[16]}}, pair_sum_s};
  end

  // Accumulator update: first word of a row loads, later words add with wrap.
  always_comb begin
    acc_d = acc_q;
    if (data_vld_q) begin
      if (first_q) begin
        acc_d = pair_ext_s;
      end else begin
        acc_d = acc_q + pair_ext_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    r_d        = r_q;
    rd_en_d    = 1'b0;
    tok_addr_d = tok_addr_q;
    wt_addr_d  = wt_addr_q;
    busy_d     = 1'b1;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    idx_d      = idx_q;
    res_d      = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_matmul) begin
          state_d    = S_FETCH;
          k_d        = K_ZERO;
          r_d        = R_ZERO;
          rd_en_d    = 1'b1;
          tok_addr_d = A_ZERO;
          wt_addr_d  = A_ZERO;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d        = k_q + K_ONE;
          rd_en_d    = 1'b1;
          tok_addr_d = tok_addr_q + A_ONE;
          wt_addr_d  = wt_addr_q + A_ONE;
        end
      end
      S_DRAIN: begin
        // Last word lands in acc_d this cycle, so the result is captured from it.
        state_d = S_EMIT;
        valid_d = 1'b1;
        idx_d   = r_q;
        res_d   = emit_value(acc_d);
      end
      S_EMIT: begin
        if (r_q == R_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          // Weight rows are contiguous, so the next row starts one word on.
          state_d    = S_FETCH;
          r_d        = r_q + R_ONE;
          k_d        = K_ZERO;
          rd_en_d    = 1'b1;
          tok_addr_d = A_ZERO;
          wt_addr_d  = wt_addr_q + A_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= K_ZERO;
      r_q        <= R_ZERO;
      rd_en_q    <= 1'b0;
      tok_addr_q <= A_ZERO;
      wt_addr_q  <= A_ZERO;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= R_ZERO;
      res_q      <= ACC_ZERO;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_q        <= r_d;
      rd_en_q    <= rd_en_d;
      tok_addr_q <= tok_addr_d;
      wt_addr_q  <= wt_addr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
    end
  end

  // Data path: track which cycle carries returned BRAM data, and accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld_q <= 1'b0;
      first_q    <= 1'b0;
      acc_q      <= ACC_ZERO;
    end else begin
      data_vld_q <= rd_en_q;
      first_q    <= rd_en_q && (k_q == K_ZERO);
      acc_q      <= acc_d;
    end
  end

  assign bus.token_rd_en    = rd_en_q;
  assign bus.weight_rd_en   = rd_en_q;
  assign bus.token_rd_addr  = tok_addr_q;
  assign bus.weight_rd_addr = wt_addr_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = valid_q;
  assign bus.result_idx     = idx_q;
  assign bus.result_data    = res_q;
  assign bus.done           = done_q;

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Int8 matrix-vector multiply stage that sits directly downstream of the serial loader. On a `start_matmul` pulse it streams the token vector and the weight matrix out of the two loader BRAMs through their read ports. It computes one signed dot product per weight row and emits each result with a one-cycle valid strobe. Each 16-bit BRAM word packs two signed int8 elements, and the engine performs two MACs per cycle.

## Interface
- `ADDR_WIDTH`, default 10: BRAM address width; must satisfy `NUM_OUT*VEC_LEN/2 <= 2**ADDR_WIDTH`.
- `DATA_WIDTH`, default 16: BRAM word width; fixed at 16 (two int8 lanes).
- `VEC_LEN`, default 64: int8 elements per vector; must be even. W = VEC_LEN/2 words.
- `NUM_OUT`, default 16: weight rows, which is also the number of results.
- `ACC_WIDTH`, default 32: accumulator and result width; must be at least 18.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start_matmul`, in, 1: start pulse; ignored while `busy`.
- `token_rd_en`, out, 1: token RAM read enable.
- `token_rd_addr`, out, ADDR_WIDTH: token word address.
- `token_rd_data`, in, DATA_WIDTH: valid one cycle after `token_rd_en`.
- `weight_rd_en`, out, 1: weight RAM read enable.
- `weight_rd_addr`, out, ADDR_WIDTH: weight word address.
- `weight_rd_data`, in, DATA_WIDTH: valid one cycle after `weight_rd_en`.
- `busy`, out, 1: high from the first FETCH cycle through the DONE cycle.
- `result_valid`, out, 1: one-cycle strobe per row.
- `result_idx`, out, clog2(NUM_OUT) bits: row index of the current result.
- `result_data`, out, ACC_WIDTH: signed dot product.
- `done`, out, 1: one-cycle pulse after the last result.

## Operation
- Data layout:
  - Token word k holds element 2k in bits [7:0] and element 2k+1 in bits [15:8], both two's complement.
  - Weight row r, word k is at address r*W+k and uses the same lane packing.
- States: IDLE, FETCH, DRAIN, EMIT, DONE.
- IDLE: `start_matmul`=1 clears the row counter r and word counter k, then moves to FETCH.
- FETCH:
  - Asserts both `rd_en` with `token_rd_addr`=k and `weight_rd_addr`=r*W+k.
  - k increments each cycle. After k=W-1 the state goes to DRAIN.
- Data path: the product pair of the word issued in the previous cycle is accumulated every cycle that data returns.
  - Products: p_lo = t[7:0]*w[7:0] and p_hi = t[15:8]*w[15:8], signed 16-bit each.
  - Sum: p_lo+p_hi, 17-bit signed, sign-extended to ACC_WIDTH.
  - The first word of each row loads the accumulator; later words add to it, wrapping modulo 2**ACC_WIDTH.
- DRAIN: the last word of the row accumulates; both `rd_en` are low.
- EMIT:
  - `result_valid`=1, `result_idx`=r, `result_data` = final accumulator.
  - If r=NUM_OUT-1, go to DONE. Otherwise r increments, k clears, and the state goes to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- `start_matmul` arriving in any state other than IDLE is dropped and not queued.
- `rd_addr` outputs hold their last value while `rd_en` is low.

## Timing
- Reset values: state IDLE; `token_rd_en`, `weight_rd_en`, `busy`, `result_valid`, `done` = 0; all addresses, `result_idx`, `result_data` and the accumulator = 0.
- The start pulse is sampled in cycle 0. FETCH occupies cycles 1..W, DRAIN is cycle W+1, and EMIT for row 0 is cycle W+2.
- Row period is W+2 cycles, back-to-back with no gap. Row r's EMIT is at cycle (r+1)*(W+2).
- `done` is at cycle NUM_OUT*(W+2)+1, and `busy` falls in the following cycle. Total cycle count is identical for every run.
- A new `start_matmul` is accepted in the first IDLE cycle after DONE.
- If `rst_n` is asserted mid-operation, everything immediately returns to reset values. No `result_valid` or `done` is produced, and the partial accumulator is discarded.
- The block never writes the BRAMs, so write/read collisions in the loader BRAMs are the loader's concern. The loader must not write during `busy`.

## Configuration
- `MATMUL_SATURATE_EN` defined: in EMIT, `result_data` is the accumulator clamped to [-32768, 32767] and sign-extended to ACC_WIDTH. The accumulator itself still wraps.
- `MATMUL_SATURATE_EN` undefined: `result_data` is the raw ACC_WIDTH accumulator, and there is no clamp logic.

## Test plan
- Reset behaviour: assert `rst_n`=0 with `start_matmul` toggling. All outputs must stay 0 and both `rd_en` must stay low.
- Identity row: VEC_LEN=4, NUM_OUT=2; tokens {1,2,3,4}; row0 = {1,0,0,0}, row1 = {1,1,1,1}. Required: results 1 then 10, EMIT at cycles 4 and 8, `done` at cycle 9.
- Sign handling: tokens all -128 (0x80), weights all -128, VEC_LEN=64. Each row must give 64*16384 = 1048576. With `MATMUL_SATURATE_EN` defined, the output must instead be 32767.
- Negative result: tokens all 127, weights all -1. Result -8128 per row at VEC_LEN=64, unaffected by saturation.
- Busy-ignore: pulse `start_matmul` again during FETCH of row 3. There must be exactly NUM_OUT results, one `done`, and an unchanged cycle count.
- Reset mid-operation: drop `rst_n` during row 5 DRAIN, then restart. Results for rows 0..NUM_OUT-1 must be correct, and no stale accumulator may appear in row 0.
